mrv32_wb_ctrl: RTL and testbench

Writeback controller that owns the single integer register-file write port (reg_wen/rd_addr/rd_data) on the producer side. It merges single-cycle ALU results with late load results from the LSU, using a small load-result queue. It keeps a per-register pending-load scoreboard so issue can stall on RAW/WAW hazards. It also forwards the write currently in flight, because register-file read-during-write is not guaranteed.

---
 rtl/mrv32_pkg.sv | 14 +
 rtl/mrv32_wb_fifo.sv | 65 ++++++
 rtl/mrv32_wb_ctrl.sv | 121 ++++++++++++
 tb/tb_mrv32_wb_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mrv32_pkg.sv
// Shared widths and payload types for the mrv32 writeback path.
package mrv32_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    // One register-file write request: destination and data.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage : mrv32_pkg

// File: rtl/mrv32_wb_fifo.sv
// Load-result queue: small FIFO of wb_req_t with wrap-around pointers and a count.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset (empties the queue)
//   push_valid   offer push_data; taken only when the queue is not full
//   push_data    request to enqueue
//   pop_ready    consumer takes the head this cycle; ignored when empty
//   pop_data     current head entry (meaningful only when count != 0)
//   count        number of occupied entries
module mrv32_wb_fifo
    import mrv32_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    input  wb_req_t                    push_data,
    input  logic                       pop_ready,
    output wb_req_t                    pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Handshakes are qualified here so a careless caller cannot over/underflow.
    assign do_push  = push_valid && (count < CW'(DEPTH));
    assign do_pop   = pop_ready && (count != '0);
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : mrv32_wb_fifo

// File: rtl/mrv32_wb_ctrl.sv
// Writeback controller: owns the single RF write port, merges ALU results with
// queued load results, tracks pending loads for hazard stalls, and forwards
// the write in flight.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data       single-cycle ALU result (never stalled)
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  load result handshake into the queue
//   iss_load/iss_load_rd            load issued this cycle (marks rd pending)
//   q_rs1_addr/q_rs2_addr/q_rd_addr issue-stage hazard query
//   hz_stall                        any queried nonzero register has a pending load
//   reg_wen/rd_addr/rd_data         registered RF write port
//   fwd_rs1_hit/fwd_rs2_hit/fwd_data  bypass of the write currently in flight
module mrv32_wb_ctrl
    import mrv32_pkg::*;
#(
    parameter int unsigned LQ_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              iss_load,
    input  logic [REG_AW-1:0] iss_load_rd,
    input  logic [REG_AW-1:0] q_rs1_addr,
    input  logic [REG_AW-1:0] q_rs2_addr,
    input  logic [REG_AW-1:0] q_rd_addr,
    output logic              hz_stall,
    output logic              reg_wen,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   rd_data,
    output logic              fwd_rs1_hit,
    output logic              fwd_rs2_hit,
    output logic [XLEN-1:0]   fwd_data
);

    localparam int unsigned CW = $clog2(LQ_DEPTH + 1);

    wb_req_t             lq_push;
    wb_req_t             lq_head;
    logic [CW-1:0]       lq_count;
    logic                lq_push_valid;
    logic                head_valid;
    logic                alu_sel;
    logic                pop_en;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Load results to x0 are accepted but never enter the queue.
    assign lq_push_valid = lsu_valid && (lsu_rd != '0);
    assign lq_push       = '{rd: lsu_rd, data: lsu_data};
    assign lsu_ready     = (lq_count < CW'(LQ_DEPTH));
    assign head_valid    = (lq_count != '0);

    // ALU has fixed priority; the queue drains only in ALU bubbles.
    assign alu_sel = alu_valid && (alu_rd != '0);
    assign pop_en  = !alu_sel && head_valid;

    mrv32_wb_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (lq_push_valid),
        .push_data  (lq_push),
        .pop_ready  (pop_en),
        .pop_data   (lq_head),
        .count      (lq_count)
    );

    // RF write port register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_wen <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (alu_sel) begin
            reg_wen <= 1'b1;
            rd_addr <= alu_rd;
            rd_data <= alu_data;
        end else if (head_valid) begin
            reg_wen <= 1'b1;
            rd_addr <= lq_head.rd;
            rd_data <= lq_head.data;
        end else begin
            reg_wen <= 1'b0;
        end
    end

    // Pending-load scoreboard: clear on pop, set on issue (set wins), x0 pinned low.
    always_comb begin
        pending_nxt = pending;
        if (pop_en) begin
            pending_nxt[lq_head.rd] = 1'b0;
        end
        if (iss_load && (iss_load_rd != '0)) begin
            pending_nxt[iss_load_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign hz_stall = pending[q_rs1_addr] | pending[q_rs2_addr] | pending[q_rd_addr];

    // Bypass of the in-flight write; RF read-during-write is not guaranteed.
    assign fwd_rs1_hit = reg_wen && (q_rs1_addr != '0) && (q_rs1_addr == rd_addr);
    assign fwd_rs2_hit = reg_wen && (q_rs2_addr != '0) && (q_rs2_addr == rd_addr);
    assign fwd_data    = rd_data;

endmodule : mrv32_wb_ctrl

// File: tb/tb_mrv32_wb_ctrl.sv
// Directed, table-driven bench for the writeback controller.
module tb_mrv32_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        iss_load;
    logic [4:0]  iss_load_rd;
    logic [4:0]  q_rs1_addr;
    logic [4:0]  q_rs2_addr;
    logic [4:0]  q_rd_addr;
    logic        hz_stall;
    logic        reg_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        fwd_rs1_hit;
    logic        fwd_rs2_hit;
    logic [31:0] fwd_data;

    int n_pass;
    int n_tot;

    mrv32_wb_ctrl #(.LQ_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .iss_load    (iss_load),
        .iss_load_rd (iss_load_rd),
        .q_rs1_addr  (q_rs1_addr),
        .q_rs2_addr  (q_rs2_addr),
        .q_rd_addr   (q_rd_addr),
        .hz_stall    (hz_stall),
        .reg_wen     (reg_wen),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .fwd_rs1_hit (fwd_rs1_hit),
        .fwd_rs2_hit (fwd_rs2_hit),
        .fwd_data    (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle plus the outputs expected just before that cycle's edge.
    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic        il;
        logic [4:0]  ilr;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic [4:0]  qd;
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        rdy;
        logic        stall;
        logic        f1;
        logic        f2;
    } vec_t;

    localparam int NV = 26;
    vec_t tbl [NV];

    function automatic vec_t mk(input int rst, input int av, input int ar, input logic [31:0] ad,
                                input int lv, input int lr, input logic [31:0] ld,
                                input int il, input int ilr, input int q1, input int q2, input int qd,
                                input int wen, input int addr, input logic [31:0] data,
                                input int rdy, input int stall, input int f1, input int f2);
        vec_t v;
        v.rst = 1'(rst);  v.av = 1'(av);   v.ar = 5'(ar);  v.ad = ad;
        v.lv = 1'(lv);    v.lr = 5'(lr);   v.ld = ld;
        v.il = 1'(il);    v.ilr = 5'(ilr);
        v.q1 = 5'(q1);    v.q2 = 5'(q2);   v.qd = 5'(qd);
        v.wen = 1'(wen);  v.addr = 5'(addr); v.data = data;
        v.rdy = 1'(rdy);  v.stall = 1'(stall); v.f1 = 1'(f1); v.f2 = 1'(f2);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n       = v.rst;
        alu_valid   = v.av;   alu_rd = v.ar;  alu_data = v.ad;
        lsu_valid   = v.lv;   lsu_rd = v.lr;  lsu_data = v.ld;
        iss_load    = v.il;   iss_load_rd = v.ilr;
        q_rs1_addr  = v.q1;   q_rs2_addr = v.q2;  q_rd_addr = v.qd;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_load = 1'b0;  iss_load_rd = '0;
        q_rs1_addr = '0;  q_rs2_addr = '0; q_rd_addr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        n_pass = 0;
        n_tot  = 0;

        // ALU write, forwarding
        tbl[0]  = mk(1, 1,5,32'hDEADBEEF, 0,0,0, 0,0, 0,0,0,   0,0,32'h0,         1,0,0,0);
        tbl[1]  = mk(1, 0,0,0,            0,0,0, 0,0, 5,0,0,   1,5,32'hDEADBEEF,  1,0,1,0);
        // load through scoreboard and queue
        tbl[2]  = mk(1, 0,0,0,            0,0,0, 1,7, 0,7,0,   0,5,32'hDEADBEEF,  1,0,0,0);
        tbl[3]  = mk(1, 0,0,0,            0,0,0, 0,0, 0,7,0,   0,5,32'hDEADBEEF,  1,1,0,0);
        tbl[4]  = mk(1, 0,0,0,            1,7,32'h12345678, 0,0, 0,7,0, 0,5,32'hDEADBEEF, 1,1,0,0);
        tbl[5]  = mk(1, 0,0,0,            0,0,0, 0,0, 0,7,0,   0,5,32'hDEADBEEF,  1,1,0,0);
        tbl[6]  = mk(1, 0,0,0,            0,0,0, 0,0, 0,7,0,   1,7,32'h12345678,  1,0,0,1);
        // x0 on every path
        tbl[7]  = mk(1, 1,0,32'hAAAA5555, 1,0,32'h55, 1,0, 0,0,0, 0,7,32'h12345678, 1,0,0,0);
        tbl[8]  = mk(1, 0,0,0,            0,0,0, 0,0, 0,0,0,   0,7,32'h12345678,  1,0,0,0);
        tbl[9]  = mk(1, 0,0,0,            0,0,0, 0,0, 7,7,7,   0,7,32'h12345678,  1,0,0,0);
        // ALU starves queue, backpressure, FIFO order
        tbl[10] = mk(1, 1,10,32'hA0,      1,1,32'h11, 0,0, 0,0,0, 0,7,32'h12345678, 1,0,0,0);
        tbl[11] = mk(1, 1,11,32'hA1,      1,2,32'h22, 0,0, 0,0,0, 1,10,32'hA0,      1,0,0,0);
        tbl[12] = mk(1, 1,12,32'hA2,      1,3,32'h33, 0,0, 0,0,0, 1,11,32'hA1,      0,0,0,0);
        tbl[13] = mk(1, 1,13,32'hA3,      1,3,32'h33, 0,0, 0,0,0, 1,12,32'hA2,      0,0,0,0);
        tbl[14] = mk(1, 0,0,0,            1,3,32'h33, 0,0, 0,0,0, 1,13,32'hA3,      0,0,0,0);
        tbl[15] = mk(1, 0,0,0,            1,3,32'h33, 0,0, 0,0,0, 1,1,32'h11,       1,0,0,0);
        tbl[16] = mk(1, 0,0,0,            0,0,0, 0,0, 0,0,0,   1,2,32'h22,        1,0,0,0);
        tbl[17] = mk(1, 0,0,0,            0,0,0, 0,0, 3,3,0,   1,3,32'h33,        1,0,1,1);
        tbl[18] = mk(1, 0,0,0,            0,0,0, 0,0, 0,0,0,   0,3,32'h33,        1,0,0,0);
        // reset with loads queued and pending
        tbl[19] = mk(1, 1,14,32'hB0,      0,0,0, 1,20, 0,0,0,  0,3,32'h33,        1,0,0,0);
        tbl[20] = mk(1, 1,15,32'hB1,      1,20,32'hC0, 1,21, 20,0,0, 1,14,32'hB0, 1,1,0,0);
        tbl[21] = mk(1, 1,16,32'hB2,      1,21,32'hC1, 0,0, 20,21,0, 1,15,32'hB1, 1,1,0,0);
        tbl[22] = mk(0, 1,17,32'hB3,      0,0,0, 0,0, 20,21,0, 1,16,32'hB2,       0,1,0,0);
        tbl[23] = mk(1, 0,0,0,            0,0,0, 0,0, 20,21,0, 0,0,32'h0,         1,0,0,0);
        tbl[24] = mk(1, 0,0,0,            0,0,0, 0,0, 20,21,0, 0,0,32'h0,         1,0,0,0);
        tbl[25] = mk(1, 0,0,0,            0,0,0, 0,0, 20,21,0, 0,0,32'h0,         1,0,0,0);

        // Reset held two cycles with the ALU active
        idle_inputs();
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst wen",  32'(reg_wen),   32'h0);
        chk("rst addr", 32'(rd_addr),   32'h0);
        chk("rst data", rd_data,        32'h0);
        chk("rst rdy",  32'(lsu_ready), 32'h1);
        for (int i = 0; i < 32; i++) begin
            q_rs1_addr = 5'(i); q_rs2_addr = 5'(i); q_rd_addr = 5'(i);
            #1;
            chk($sformatf("rst stall q%0d", i), 32'(hz_stall), 32'h0);
        end
        @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            drive(tbl[k]);
            #1;
            chk($sformatf("v%0d wen", k),   32'(reg_wen),     32'(tbl[k].wen));
            chk($sformatf("v%0d addr", k),  32'(rd_addr),     32'(tbl[k].addr));
            chk($sformatf("v%0d data", k),  rd_data,          tbl[k].data);
            chk($sformatf("v%0d fdata", k), fwd_data,         tbl[k].data);
            chk($sformatf("v%0d rdy", k),   32'(lsu_ready),   32'(tbl[k].rdy));
            chk($sformatf("v%0d stall", k), 32'(hz_stall),    32'(tbl[k].stall));
            chk($sformatf("v%0d f1", k),    32'(fwd_rs1_hit), 32'(tbl[k].f1));
            chk($sformatf("v%0d f2", k),    32'(fwd_rs2_hit), 32'(tbl[k].f2));
            @(negedge clk);
        end

        // Load latency: one edge after acceptance the write is visible
        rst_n = 1'b1;
        idle_inputs();
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
        #1;
        chk("lat rdy", 32'(lsu_ready), 32'h1);
        @(negedge clk);
        idle_inputs();
        cnt = 0;
        while (reg_wen !== 1'b1 && cnt < 8) begin
            @(negedge clk);
            cnt++;
        end
        chk("lat edges", 32'(cnt),     32'd1);
        chk("lat addr",  32'(rd_addr), 32'd9);
        chk("lat data",  rd_data,      32'h99);

        // Pop and re-issue of the same register in one cycle: set wins
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9A;
        @(negedge clk);
        idle_inputs();
        iss_load = 1'b1; iss_load_rd = 5'd9;
        @(negedge clk);
        idle_inputs();
        q_rs1_addr = 5'd9;
        #1;
        chk("sw wen",   32'(reg_wen),     32'h1);
        chk("sw addr",  32'(rd_addr),     32'd9);
        chk("sw data",  rd_data,          32'h9A);
        chk("sw stall", 32'(hz_stall),    32'h1);
        chk("sw fwd1",  32'(fwd_rs1_hit), 32'h1);
        chk("sw rdy",   32'(lsu_ready),   32'h1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule : tb_mrv32_wb_ctrl
